core_bus_arbiter: RTL
=====================

Name: core_bus_arbiter

Overview:
- Shares one downstream cache-core bus between two upstream masters: instruction-fetch (I) and data/LSU (D).
- Each master sees a private request/response channel. The arbiter issues one transaction at a time, then routes the response burst back to the owner.
- A round-robin policy prevents starvation. A response watchdog flags a hung bus.

Parameters:
- ADDR_W, 64, width of req / resp words.
- TAG_W, 13, width of reqtag / resptag.
- RESP_TIMEOUT, 1024, cycles allowed from downstream reqack to first response beat before error.

Ports:
- clk  in  1  bus clock
- reset  in  1  asynchronous, active-high reset
- i_reqcyc  in  1  I request valid; held with i_req / i_reqtag until i_reqack
- i_req  in  ADDR_W  I request address
- i_reqtag  in  TAG_W  I request tag
- i_reqack  out  1  one-cycle accept pulse to I
- i_respcyc  out  1  I response beat valid
- i_resp  out  ADDR_W  I response data
- i_resptag  out  TAG_W  I response tag
- i_respack  in  1  I accepts beat
- d_reqcyc, d_req, d_reqtag, d_reqack, d_respcyc, d_resp, d_resptag, d_respack: same as i_* for the D master
- bus_reqcyc  out  1  downstream request valid
- bus_req  out  ADDR_W  downstream address
- bus_reqtag  out  TAG_W  downstream tag
- bus_reqack  in  1  downstream accept
- bus_respcyc  in  1  downstream beat valid
- bus_resp  in  ADDR_W  downstream data
- bus_resptag  in  TAG_W  downstream tag
- bus_respack  out  1  ack to downstream
- owner  out  1  0 = I, 1 = D; valid while busy
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state = IDLE, last_grant = D (I wins first tie), owner = 0, err = 0, timer = 0; all *_reqcyc/*_reqack/*_respcyc/respack outputs 0; data/tag outputs 0. Reset mid-transaction abandons it; no ack or response is delivered afterwards.
- States: IDLE, ISSUE, WAIT_RESP, BURST.
- IDLE:
  - If exactly one reqcyc is high, grant that master.
  - If both are high, grant the master != last_grant.
  - On grant, register the winner's req/reqtag into bus_req/bus_reqtag, set owner, set bus_reqcyc = 1 next cycle, go to ISSUE.
  - Min latency from master reqcyc to bus_reqcyc: 1 cycle.
- ISSUE:
  - bus_reqcyc stays high with latched address/tag; later master input changes are ignored.
  - When bus_reqack = 1: owner's *_reqack = 1 in the same cycle (combinational, exactly one pulse); bus_reqcyc = 0 next cycle; timer = 0; go to WAIT_RESP.
  - The non-owner never sees reqack.
- WAIT_RESP:
  - timer increments each cycle.
  - When bus_respcyc = 1, go to BURST (this beat is routed as in BURST).
  - If timer reaches RESP_TIMEOUT-1 with no beat: err = 1, last_grant = owner, go to IDLE.
- BURST (routing also applies to the first beat seen in WAIT_RESP):
  - Owner's *_respcyc = bus_respcyc, *_resp = bus_resp, *_resptag = bus_resptag; bus_respack = owner's *_respack. All combinational, zero latency.
  - Non-owner respcyc = 0.
  - When bus_respcyc = 0 in BURST, the transaction ends: last_grant = owner, go to IDLE.
  - Next grant is possible in the following cycle.
- A beat seen in IDLE or ISSUE is protocol error: set err, respack = 0, no state change.
- Requests arriving while busy wait (reqcyc held). The other master is granted first after completion if it was waiting.
- Every transaction (read or write) ends with >= 1 response beat; no tag decoding.
- err clears only on reset.

Test Plan:
- Single I read: i_reqcyc=1, i_req=0x1000. Expect bus_reqcyc=1, bus_req=0x1000 next cycle. bus_reqack at cycle 3 -> i_reqack pulse at cycle 3. 8-beat burst 0xA0..0xA7 -> i_resp mirrors each beat; d_respcyc stays 0; busy falls after burst.
- Simultaneous I and D requests from reset: I granted first, D second, I third if I re-requests (round-robin alternation verified over 4 transactions).
- D request arrives during an I burst: bus_reqcyc for D not asserted until the cycle after bus_respcyc falls. d_req=0x2040 appears unchanged.
- Master changes i_req after grant while still in ISSUE: bus_req keeps the latched value.
- RESP_TIMEOUT=16, no response after reqack: err=1 at cycle 16 after ack, busy=0, next request serviced normally.
- Assert reset mid-BURST: all outputs 0 immediately (async). After release, I wins a simultaneous I/D request.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter for a single downstream cache-core bus.
// One transaction in flight; round-robin grant, response routing and response watchdog.
module core_bus_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int TAG_W        = 13,
   parameter int RESP_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_reqcyc,
   input  logic [ADDR_W-1:0] i_req,
   input  logic [TAG_W-1:0]  i_reqtag,
   output logic              i_reqack,
   output logic              i_respcyc,
   output logic [ADDR_W-1:0] i_resp,
   output logic [TAG_W-1:0]  i_resptag,
   input  logic              i_respack,
   input  logic              d_reqcyc,
   input  logic [ADDR_W-1:0] d_req,
   input  logic [TAG_W-1:0]  d_reqtag,
   output logic              d_reqack,
   output logic              d_respcyc,
   output logic [ADDR_W-1:0] d_resp,
   output logic [TAG_W-1:0]  d_resptag,
   input  logic              d_respack,
   output logic              bus_reqcyc,
   output logic [ADDR_W-1:0] bus_req,
   output logic [TAG_W-1:0]  bus_reqtag,
   input  logic              bus_reqack,
   input  logic              bus_respcyc,
   input  logic [ADDR_W-1:0] bus_resp,
   input  logic [TAG_W-1:0]  bus_resptag,
   output logic              bus_respack,
   output logic              owner,
   output logic              busy,
   output logic              err
);

   localparam int TIMER_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RESP,
      ST_BURST
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic                err_q, err_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [ADDR_W-1:0]   bus_req_q, bus_req_d;
   logic [TAG_W-1:0]    bus_reqtag_q, bus_reqtag_d;
   logic                grant_d_master;
   logic                routing;
   logic                owner_respack;

   // On a tie the master that did not win last time gets the bus.
   assign grant_d_master = d_reqcyc && (!i_reqcyc || !last_grant_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      err_d        = err_q;
      timer_d      = timer_q;
      bus_req_d    = bus_req_q;
      bus_reqtag_d = bus_reqtag_q;
      case (state_q)
         ST_IDLE: begin
            if (i_reqcyc || d_reqcyc) begin
               owner_d      = grant_d_master;
               bus_req_d    = grant_d_master ? d_req : i_req;
               bus_reqtag_d = grant_d_master ? d_reqtag : i_reqtag;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus_reqack) begin
               timer_d = '0;
               state_d = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            if (bus_respcyc) begin
               state_d = ST_BURST;
            end else if (timer_q == TIMER_W'(RESP_TIMEOUT - 1)) begin
               err_d        = 1'b1;
               last_grant_d = owner_q;
               state_d      = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_BURST: begin
            if (!bus_respcyc) begin
               last_grant_d = owner_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A response beat with no transaction awaiting one is a protocol violation.
      if ((state_q == ST_IDLE || state_q == ST_ISSUE) && bus_respcyc) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         err_q        <= 1'b0;
         timer_q      <= '0;
         bus_req_q    <= '0;
         bus_reqtag_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         err_q        <= err_d;
         timer_q      <= timer_d;
         bus_req_q    <= bus_req_d;
         bus_reqtag_q <= bus_reqtag_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign owner      = owner_q;
   assign err        = err_q;
   assign bus_reqcyc = (state_q == ST_ISSUE);
   assign bus_req    = bus_req_q;
   assign bus_reqtag = bus_reqtag_q;

   assign i_reqack = bus_reqcyc && bus_reqack && !owner_q;
   assign d_reqack = bus_reqcyc && bus_reqack && owner_q;

   // The first beat can arrive while still waiting, so routing covers both states.
   assign routing       = (state_q == ST_WAIT_RESP) || (state_q == ST_BURST);
   assign owner_respack = owner_q ? d_respack : i_respack;

   assign i_respcyc   = routing && !owner_q && bus_respcyc;
   assign i_resp      = (routing && !owner_q) ? bus_resp : '0;
   assign i_resptag   = (routing && !owner_q) ? bus_resptag : '0;
   assign d_respcyc   = routing && owner_q && bus_respcyc;
   assign d_resp      = (routing && owner_q) ? bus_resp : '0;
   assign d_resptag   = (routing && owner_q) ? bus_resptag : '0;
   assign bus_respack = routing && bus_respcyc && owner_respack;

endmodule
